// File: rtl/bram_bist.sv
// March-style BIST for simple-dual-port block RAM: fill, up RMW, down RMW, down read.
// All memory-side and status outputs are registered one step ahead of the state they belong to.
module bram_bist #(
  parameter int unsigned ADDR_SZ     = 8,
  parameter int unsigned DATA_SZ     = 16,
  parameter logic [63:0] PATTERN     = 64'h5A3C,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned ERR_SZ      = 8,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [ERR_SZ-1:0]  o_err_cnt,
  output logic [ADDR_SZ-1:0] o_err_addr,
  output logic [1:0]         o_err_phase,
  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata
);

  localparam logic [DATA_SZ-1:0] PAT    = DATA_SZ'(PATTERN);
  localparam logic [ADDR_SZ:0]   LAST   = {1'b0, {ADDR_SZ{1'b1}}};
  localparam int unsigned        WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_WAIT, S_CMP, S_DONE} state_t;

  state_t              state_q;
  logic [1:0]          phase_q;
  logic [ADDR_SZ:0]    addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [ERR_SZ-1:0]   err_cnt_q;
  logic [ADDR_SZ-1:0]  err_addr_q, addr_lo;
  logic [1:0]          err_phase_q;
  logic                busy_q, done_q, pass_q, wr_en_q, rd_en_q;
  logic [ADDR_SZ-1:0]  waddr_q, raddr_q;
  logic [DATA_SZ-1:0]  wdata_q, exp_data, cmp_wdata;
  logic                mismatch, cmp_wr_en, last_addr;

  function automatic logic [DATA_SZ-1:0] pat(input logic [ADDR_SZ-1:0] a);
    return PAT ^ DATA_SZ'(a);
  endfunction

  assign addr_lo = addr_q[ADDR_SZ-1:0];

  always_comb begin
    exp_data  = (phase_q == 2'd2) ? ~pat(addr_lo) : pat(addr_lo);
    mismatch  = (i_rdata != exp_data);
    cmp_wr_en = (phase_q == 2'd1) || (phase_q == 2'd2);
    cmp_wdata = (phase_q == 2'd1) ? ~pat(addr_lo) : pat(addr_lo);
    // fill and phase 1 ascend to LAST; phases 2 and 3 descend to 0
    last_addr = (phase_q < 2'd2) ? (addr_q == LAST) : (addr_q == '0);
    addr_d    = (phase_q < 2'd2) ? addr_q + 1'b1 : addr_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_phase_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      raddr_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_phase_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            phase_q     <= 2'd0;
            addr_q      <= '0;
            wr_en_q     <= 1'b1;
            waddr_q     <= '0;
            wdata_q     <= pat('0);
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (last_addr) begin
            phase_q <= 2'd1;
            addr_q  <= '0;
            rd_en_q <= 1'b1;
            raddr_q <= '0;
            state_q <= S_RD;
          end else begin
            addr_q  <= addr_d;
            wr_en_q <= 1'b1;
            waddr_q <= addr_d[ADDR_SZ-1:0];
            wdata_q <= pat(addr_d[ADDR_SZ-1:0]);
          end
        end
        S_RD, S_WAIT: begin
          if ((state_q == S_RD && RD_LAT == 1) ||
              (state_q == S_WAIT && wait_q == WAIT_W'(RD_LAT - 2))) begin
            // write-back data does not depend on the compare, so it is issued with CMP
            wr_en_q <= cmp_wr_en;
            waddr_q <= addr_lo;
            wdata_q <= cmp_wdata;
            state_q <= S_CMP;
          end else begin
            wait_q  <= (state_q == S_RD) ? '0 : wait_q + 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_CMP: begin
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
              err_addr_q  <= addr_lo;
              err_phase_q <= phase_q;
            end
          end
          if ((mismatch && STOP_ON_ERR) || (last_addr && phase_q == 2'd3)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_q == '0) && !mismatch;
            state_q <= S_DONE;
          end else if (last_addr) begin
            phase_q <= phase_q + 1'b1;
            addr_q  <= LAST;
            rd_en_q <= 1'b1;
            raddr_q <= LAST[ADDR_SZ-1:0];
            state_q <= S_RD;
          end else begin
            addr_q  <= addr_d;
            rd_en_q <= 1'b1;
            raddr_q <= addr_d[ADDR_SZ-1:0];
            state_q <= S_RD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_phase = err_phase_q;
  assign o_wr_en     = wr_en_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_rd_en     = rd_en_q;
  assign o_raddr     = raddr_q;

endmodule

// File: tb/tb_bram_bist.sv
// Directed bench for bram_bist: four instances with behavioural memories and injectable faults.
// Latency is counted with the edge that samples i_start as cycle 1.
module tb_bram_bist;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] start_v;
  logic [3:0] done_v;
  int checks = 0;
  int failures = 0;

  // A: 16x8, PATTERN 00, RD_LAT 1, run-time fault select
  logic a_busy, a_done, a_pass, a_wr, a_rd;
  logic [7:0] a_err, a_wd, a_rdata;
  logic [3:0] a_eaddr, a_wa, a_ra;
  logic [1:0] a_eph;
  bram_bist #(.ADDR_SZ(4), .DATA_SZ(8), .PATTERN(64'h00), .RD_LAT(1), .ERR_SZ(8), .STOP_ON_ERR(1'b0)) dA (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_cnt(a_err), .o_err_addr(a_eaddr), .o_err_phase(a_eph), .o_wr_en(a_wr), .o_waddr(a_wa),
    .o_wdata(a_wd), .o_rd_en(a_rd), .o_raddr(a_ra), .i_rdata(a_rdata));

  // S: as A but stop on first error, memory always aliases 9 onto 1
  logic s_busy, s_done, s_pass, s_wr, s_rd;
  logic [7:0] s_err, s_wd, s_rdata;
  logic [3:0] s_eaddr, s_wa, s_ra;
  logic [1:0] s_eph;
  bram_bist #(.ADDR_SZ(4), .DATA_SZ(8), .PATTERN(64'h00), .RD_LAT(1), .ERR_SZ(8), .STOP_ON_ERR(1'b1)) dS (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
    .o_err_cnt(s_err), .o_err_addr(s_eaddr), .o_err_phase(s_eph), .o_wr_en(s_wr), .o_waddr(s_wa),
    .o_wdata(s_wd), .o_rd_en(s_rd), .o_raddr(s_ra), .i_rdata(s_rdata));

  // L: 16x8, default pattern, two-cycle read latency
  logic l_busy, l_done, l_pass, l_wr, l_rd;
  logic [7:0] l_err, l_wd, l_rdata, l_p1;
  logic [3:0] l_eaddr, l_wa, l_ra;
  logic [1:0] l_eph;
  bram_bist #(.ADDR_SZ(4), .DATA_SZ(8), .RD_LAT(2)) dL (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .o_busy(l_busy), .o_done(l_done), .o_pass(l_pass),
    .o_err_cnt(l_err), .o_err_addr(l_eaddr), .o_err_phase(l_eph), .o_wr_en(l_wr), .o_waddr(l_wa),
    .o_wdata(l_wd), .o_rd_en(l_rd), .o_raddr(l_ra), .i_rdata(l_rdata));

  // B: 128x8, memory returns inverted data so every compare fails (384 mismatches)
  logic b_busy, b_done, b_pass, b_wr, b_rd;
  logic [7:0] b_err, b_wd, b_rdata;
  logic [6:0] b_eaddr, b_wa, b_ra;
  logic [1:0] b_eph;
  bram_bist #(.ADDR_SZ(7), .DATA_SZ(8), .RD_LAT(1), .ERR_SZ(8)) dB (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[3]), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_cnt(b_err), .o_err_addr(b_eaddr), .o_err_phase(b_eph), .o_wr_en(b_wr), .o_waddr(b_wa),
    .o_wdata(b_wd), .o_rd_en(b_rd), .o_raddr(b_ra), .i_rdata(b_rdata));

  assign done_v = {b_done, l_done, s_done, a_done};

  logic [7:0] mem_a [16];
  logic [7:0] mem_s [16];
  logic [7:0] mem_l [16];
  logic [7:0] mem_b [128];
  int fault_a = 0;
  int a_wcnt = 0, a_rcnt = 0, a_both = 0;

  function automatic logic [3:0] alias9(input logic [3:0] a);
    return (a == 4'd9) ? 4'd1 : a;
  endfunction

  always @(posedge clk) begin
    if (a_wr) mem_a[(fault_a == 2) ? alias9(a_wa) : a_wa] <= a_wd;
    if (a_rd) a_rdata <= mem_a[(fault_a == 2) ? alias9(a_ra) : a_ra]
                         | ((fault_a == 1 && a_ra == 4'd5) ? 8'h08 : 8'h00);
    if (a_wr) a_wcnt++;
    if (a_rd) a_rcnt++;
    if (a_wr && a_rd) a_both++;
    if (s_wr) mem_s[alias9(s_wa)] <= s_wd;
    if (s_rd) s_rdata <= mem_s[alias9(s_ra)];
    if (l_wr) mem_l[l_wa] <= l_wd;
    if (l_rd) l_p1 <= mem_l[l_ra];
    l_rdata <= l_p1;
    if (b_wr) mem_b[b_wa] <= b_wd;
    if (b_rd) b_rdata <= ~mem_b[b_ra];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int k, input int limit, input bit pulse_busy, output int cyc);
    @(negedge clk) start_v[k] = 1'b1;
    @(posedge clk) cyc = 1;
    @(negedge clk) start_v[k] = 1'b0;
    while (done_v[k] !== 1'b1 && cyc < limit) begin
      start_v[k] = pulse_busy && (cyc == 30 || cyc == 90);
      @(posedge clk) cyc++;
      @(negedge clk);
    end
    start_v[k] = 1'b0;
  endtask

  initial begin
    int cyc, wbase, rbase, bad;
    rst = 1'b1;
    start_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", |{a_busy, a_done, a_pass, a_err, a_eaddr, a_eph, a_wr, a_wa, a_wd, a_rd, a_ra}, 0);
    @(negedge clk) rst = 1'b0;

    // ideal memory
    fault_a = 0; wbase = a_wcnt; rbase = a_rcnt;
    run(0, 140, 1'b0, cyc);
    check("ideal_latency", cyc, 113);
    check("ideal_done", a_done, 1);
    check("ideal_pass", a_pass, 1);
    check("ideal_err_cnt", a_err, 0);
    check("ideal_busy", a_busy, 0);
    check("ideal_writes", a_wcnt - wbase, 48);
    check("ideal_reads", a_rcnt - rbase, 48);
    check("rd_wr_overlap", a_both, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem_a[i] !== 8'(i)) bad++;
    check("ideal_mem_final", bad, 0);

    // bit 3 stuck at 1 at address 5
    fault_a = 1;
    run(0, 140, 1'b0, cyc);
    check("stuck_latency", cyc, 113);
    check("stuck_pass", a_pass, 0);
    check("stuck_err_cnt", a_err, 2);
    check("stuck_err_addr", a_eaddr, 5);
    check("stuck_err_phase", a_eph, 1);

    // reset at cycle 40, then clean rerun with start pulses while busy
    fault_a = 0;
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk) start_v[0] = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    check("busy_before_rst", a_busy, 1);
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", |{a_busy, a_done, a_pass, a_err, a_eaddr, a_eph, a_wr, a_wa, a_wd, a_rd, a_ra}, 0);
    @(negedge clk) rst = 1'b0;
    run(0, 140, 1'b1, cyc);
    check("rerun_latency", cyc, 113);
    check("rerun_pass", a_pass, 1);
    check("rerun_err_cnt", a_err, 0);

    // address 9 aliases onto 1
    fault_a = 2;
    run(0, 140, 1'b0, cyc);
    check("alias_err_nonzero", a_err != 0, 1);
    check("alias_err_cnt", a_err, 4);
    check("alias_err_addr", a_eaddr, 1);
    check("alias_err_phase", a_eph, 1);
    check("alias_pass", a_pass, 0);

    // aliasing with stop-on-error
    run(1, 60, 1'b0, cyc);
    check("stop_latency", cyc, 21);
    check("stop_err_cnt", s_err, 1);
    check("stop_err_addr", s_eaddr, 1);
    check("stop_err_phase", s_eph, 1);
    check("stop_pass", s_pass, 0);
    check("stop_busy", s_busy, 0);

    // two-cycle read latency
    run(2, 200, 1'b0, cyc);
    check("lat2_latency", cyc, 161);
    check("lat2_pass", l_pass, 1);
    check("lat2_err_cnt", l_err, 0);

    // error counter saturation
    run(3, 950, 1'b0, cyc);
    check("sat_latency", cyc, 897);
    check("sat_err_cnt", b_err, 255);
    check("sat_pass", b_pass, 0);
    check("sat_err_addr", b_eaddr, 0);
    check("sat_err_phase", b_eph, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
